// File: rtl/nav_sequencer.sv
// Navigation command sequencer: accepts ZERO/CRUISE/JUMP/STOP commands and drives
// the position/velocity mode selects; a jump runs charge -> one-cycle jump -> cooldown.
module nav_sequencer #(
   parameter int K               = 16,
   parameter int CHARGE_CYCLES   = 4,
   parameter int COOLDOWN_CYCLES = 8,
   parameter int CNT_W           = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [3:0]       cmd_mode_i,
   input  logic [3*K-1:0]   cmd_target_i,
   input  logic             abort_i,
   output logic [3:0]       pos_mode_o,
   output logic [3:0]       mode_o,
   output logic [3*K-1:0]   jump_position_o,
   output logic             cmd_err_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [2:0] StZero     = 3'd0;
   localparam logic [2:0] StIdle     = 3'd1;
   localparam logic [2:0] StCruise   = 3'd2;
   localparam logic [2:0] StCharge   = 3'd3;
   localparam logic [2:0] StJump     = 3'd4;
   localparam logic [2:0] StCooldown = 3'd5;

   localparam logic [1:0] OpZero   = 2'b00;
   localparam logic [1:0] OpCruise = 2'b01;
   localparam logic [1:0] OpJump   = 2'b10;
   localparam logic [1:0] OpStop   = 2'b11;

   localparam logic [3:0] ModeZeroSpeed = 4'b0001;
   localparam logic [3:0] PosReset      = 4'b0001;
   localparam logic [3:0] PosSublight   = 4'b0010;
   localparam logic [3:0] PosJump       = 4'b0100;

   logic [2:0]       state_q, state_d;
   logic [3:0]       cruise_q, cruise_d;
   logic [3*K-1:0]   jump_pos_q, jump_pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             ready_q;
   logic [3:0]       pos_mode_q, mode_q;
   logic             accept;

   assign accept = cmd_valid_i && ready_q;

   // Next-state and datapath-latch logic; cnt is zero in every state that does not count.
   always_comb begin
      state_d    = state_q;
      cruise_d   = cruise_q;
      jump_pos_d = jump_pos_q;
      cnt_d      = '0;
      err_d      = 1'b0;
      case (state_q)
         StZero: state_d = StIdle;
         StIdle, StCruise: begin
            if (accept) begin
               case (cmd_op_i)
                  OpZero: state_d = StZero;
                  OpStop: state_d = StIdle;
                  OpJump: begin
                     state_d    = StCharge;
                     jump_pos_d = cmd_target_i;
                     cnt_d      = CNT_W'(CHARGE_CYCLES - 1);
                  end
                  OpCruise: begin
                     case (cmd_mode_i)
                        4'b0010, 4'b0100, 4'b1000: begin
                           state_d  = StCruise;
                           cruise_d = cmd_mode_i;
                        end
                        ModeZeroSpeed: state_d = StIdle;
                        default:       err_d   = 1'b1;
                     endcase
                  end
                  default: state_d = state_q;
               endcase
            end
         end
         StCharge: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (cnt_q == '0) begin
               state_d = StJump;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StJump: begin
            state_d = StCooldown;
            cnt_d   = CNT_W'(COOLDOWN_CYCLES - 1);
         end
         StCooldown: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = StZero;
      endcase
   end

   // Outputs are registered from the next state so they change exactly with the state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StZero;
         cruise_q   <= ModeZeroSpeed;
         jump_pos_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
         pos_mode_q <= PosReset;
         mode_q     <= ModeZeroSpeed;
      end else begin
         state_q    <= state_d;
         cruise_q   <= cruise_d;
         jump_pos_q <= jump_pos_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         ready_q    <= (state_d == StIdle) || (state_d == StCruise);
         pos_mode_q <= (state_d == StZero) ? PosReset :
                       (state_d == StJump) ? PosJump  : PosSublight;
         mode_q     <= (state_d == StCruise) ? cruise_d : ModeZeroSpeed;
      end
   end

   assign cmd_ready_o     = ready_q;
   assign pos_mode_o      = pos_mode_q;
   assign mode_o          = mode_q;
   assign jump_position_o = jump_pos_q;
   assign cmd_err_o       = err_q;
   assign cnt_o           = cnt_q;

endmodule

// File: doc/nav_sequencer.md
# nav_sequencer

Command sequencer for the ship's motion datapath. It accepts navigation commands (zero, cruise, jump, stop) over a valid/ready handshake and drives the one-hot `pos_mode` and `mode` selects plus the `jump_position` vector consumed by the position and velocity blocks. A jump is a fixed sequence: charge, one-cycle jump, cooldown. Every output is registered and decoded from state (Moore machine).

## Interface
- `K`, 16, per-axis coordinate width
- `CHARGE_CYCLES`, 4, cycles spent in CHARGE before the jump (≥1)
- `COOLDOWN_CYCLES`, 8, cycles spent in COOLDOWN after the jump (≥1)
- `CNT_W`, 8, counter width; must hold max(CHARGE_CYCLES, COOLDOWN_CYCLES)-1

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted this cycle
- `cmd_op`  in  2  00 ZERO, 01 CRUISE, 10 JUMP, 11 STOP
- `cmd_mode`  in  4  one-hot combat mode for CRUISE: 0001 zero speed, 0010 attack, 0100 defense, 1000 stealth
- `cmd_target`  in  3K  jump target {X,Y,Z}
- `abort`  in  1  cancels a jump while in CHARGE
- `pos_mode`  out  4  position select: 0001 reset, 0010 sublight, 0100 jump
- `mode`  out  4  velocity mode, same encoding as `cmd_mode`
- `jump_position`  out  3K  latched jump target {X,Y,Z}
- `cmd_err`  out  1  one-cycle pulse: accepted command rejected as illegal
- `cnt`  out  CNT_W  cycles remaining in CHARGE/COOLDOWN; 0 elsewhere

## Operation
- States and their outputs (pos_mode / mode):
  - ZERO (0001 / 0001)
  - IDLE (0010 / 0001)
  - CRUISE (0010 / cruise_mode)
  - CHARGE (0010 / 0001)
  - JUMP (0100 / 0001)
  - COOLDOWN (0010 / 0001)
- `cmd_ready` = 1 only in IDLE and CRUISE. A command is accepted on an edge where `cmd_valid && cmd_ready`.
- Transitions on an accepted command from IDLE or CRUISE:
  - ZERO → ZERO
  - STOP → IDLE
  - CRUISE, `cmd_mode` ∈ {0010, 0100, 1000} → CRUISE, `cmd_mode` latched into cruise_mode
  - CRUISE, `cmd_mode` = 0001 → IDLE
  - CRUISE, `cmd_mode` not one-hot → state unchanged, `cmd_err` pulses
  - JUMP → CHARGE, `cmd_target` latched into `jump_position`, `cnt` loads CHARGE_CYCLES-1
- ZERO always lasts one cycle, then → IDLE.
- CHARGE:
  - `cnt` decrements each cycle.
  - At `cnt` = 0 → JUMP.
  - `abort` = 1 in any CHARGE cycle (including the `cnt` = 0 cycle) → IDLE; JUMP is never entered and `jump_position` keeps its latched value.
- JUMP lasts one cycle → COOLDOWN, with `cnt` loaded to COOLDOWN_CYCLES-1.
- COOLDOWN decrements `cnt`; at 0 → IDLE. The previous cruise_mode is not resumed.
- `abort` is ignored outside CHARGE.
- `cmd_mode` is ignored for ops other than CRUISE. `cmd_target` is ignored for ops other than JUMP.
- `jump_position` changes only on JUMP acceptance.

## Timing
- Reset (async assert, sync-to-clk release):
  - state = ZERO, so `pos_mode` = 0001 and `mode` = 0001
  - `jump_position` = 0, cruise_mode = 0001
  - `cmd_ready` = 0, `cmd_err` = 0, `cnt` = 0
- The first cycle after release is ZERO; IDLE follows on the next edge. The position datapath is therefore cleared on the first post-reset edge.
- Command accepted at edge N: the new state and outputs are visible after edge N. The datapath register samples them at edge N+1.
- A JUMP accepted at edge N shows `pos_mode` = 0100 for exactly one cycle, after edge N+CHARGE_CYCLES. COOLDOWN spans the next COOLDOWN_CYCLES cycles. `cmd_ready` reasserts after edge N+CHARGE_CYCLES+1+COOLDOWN_CYCLES.
- `cmd_err` is high only for the cycle after the accepting edge.
- Reset asserted mid-sequence (CHARGE, JUMP or COOLDOWN) aborts immediately to ZERO with all reset values. No jump completes.

## Test plan
- Reset release: outputs are 0001/0001 with `cmd_ready` = 0 for one cycle, then 0010/0001 with `cmd_ready` = 1.
- CRUISE `cmd_mode` = 0100 accepted, then STOP: `mode` = 0100 from the next cycle, then 0001 after the STOP edge; `pos_mode` holds 0010 throughout.
- CRUISE `cmd_mode` = 0110: `cmd_err` pulses for one cycle; state and `mode` are unchanged; `cmd_ready` stays 1.
- JUMP, target {0x0010, 0xFFFF, 0x1234}, defaults:
  - `jump_position` updates the cycle after acceptance.
  - `pos_mode` = 0100 for exactly one cycle, four cycles after acceptance.
  - `cnt` counts 3..0 in CHARGE, then 7..0 in COOLDOWN.
  - `cmd_ready` = 0 for 13 cycles.
- JUMP with `abort` in the 2nd CHARGE cycle: → IDLE next cycle, `pos_mode` never 0100, `cmd_ready` = 1.
- `rst_n` pulled low during COOLDOWN: outputs go to reset values immediately; ZERO then IDLE after release.
